// File: rtl/latch_seq_pkg.sv
// latch_seq_pkg
// Shared types and helpers for the latch bank write sequencer.
//   state_e      : sequencer state encoding
//   clog2        : ceiling log2, never less than 1 (usable for port widths)
//   count_width  : width of the shared down-counter for a given timing set
//   COUNT_W      : counter width for the default timing (1/2/1)
package latch_seq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWSetup,
        StWOpen,
        StWHold,
        StCPulse,
        StCRec,
        StDone
    } state_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 31; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

    function automatic int unsigned count_width(input int unsigned s,
                                                input int unsigned p,
                                                input int unsigned h);
        int unsigned m;
        m = s;
        if (p > m) m = p;
        if (h > m) m = h;
        return clog2(m + 1);
    endfunction

    localparam int unsigned COUNT_W = count_width(1, 2, 1);

endpackage

// File: rtl/latch_seq_timer.sv
// latch_seq_timer
// Loadable down-counter shared by every timed sequencer state. A phase of N
// cycles is started by loading N-1; zero rises on the phase's last cycle.
// Ports:
//   CLK      : clock, rising edge
//   RESETB   : asynchronous active-low reset (count -> 0)
//   load     : load load_val on the next edge (wins over decrement)
//   load_val : value to load
//   zero     : count is zero
module latch_seq_timer
    import latch_seq_pkg::*;
#(
    parameter int unsigned CW = COUNT_W
) (
    input  logic          CLK,
    input  logic          RESETB,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          zero
);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/latch_bank_wr_seq.sv
// latch_bank_wr_seq
// Turns four-phase write / clear-all requests into timed controls for a bank
// of NWORDS x WIDTH negative-gate, active-low-reset latches. Every output is
// a flop, so gate and reset nets never glitch.
// Ports:
//   CLK, RESETB     : clock (rising) and asynchronous active-low reset
//   wr_req          : write request (level), wr_addr/wr_data sampled in idle
//   wr_ack, wr_err  : write done (held until wr_req drops); err = bad address
//   clr_req/clr_ack : clear-all request / done (four-phase)
//   lat_d           : shared latch data bus
//   lat_gaten       : per-word gate, active low
//   lat_resetb      : per-word latch reset, active low
//   busy            : sequencer not idle
module latch_bank_wr_seq
    import latch_seq_pkg::*;
#(
    parameter int unsigned NWORDS    = 8,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned SETUP_CYC = 1,
    parameter int unsigned PULSE_CYC = 2,
    parameter int unsigned HOLD_CYC  = 1
) (
    input  logic                       CLK,
    input  logic                       RESETB,
    input  logic                       wr_req,
    input  logic [clog2(NWORDS)-1:0]   wr_addr,
    input  logic [WIDTH-1:0]           wr_data,
    output logic                       wr_ack,
    output logic                       wr_err,
    input  logic                       clr_req,
    output logic                       clr_ack,
    output logic [WIDTH-1:0]           lat_d,
    output logic [NWORDS-1:0]          lat_gaten,
    output logic [NWORDS-1:0]          lat_resetb,
    output logic                       busy
);

    localparam int unsigned AW = clog2(NWORDS);
    localparam int unsigned CW = count_width(SETUP_CYC, PULSE_CYC, HOLD_CYC);

    localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);
    localparam logic [AW:0]   NW_LIM   = (AW + 1)'(NWORDS);

    state_e          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            is_clr_q, is_clr_d;
    logic            tmr_load;
    logic [CW-1:0]   tmr_val;
    logic            tmr_zero;
    logic            addr_ok;

    logic [WIDTH-1:0]  lat_d_d;
    logic [NWORDS-1:0] gaten_d;
    logic [NWORDS-1:0] resetb_d;
    logic              wr_ack_d, wr_err_d, clr_ack_d, busy_d;

    latch_seq_timer #(
        .CW (CW)
    ) u_timer (
        .CLK      (CLK),
        .RESETB   (RESETB),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // Non-power-of-two banks leave addresses with no latch behind them.
    assign addr_ok = ({1'b0, addr_q} < NW_LIM);

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        is_clr_d = is_clr_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        lat_d_d  = lat_d;
        unique case (state_q)
            StIdle: begin
                if (clr_req) begin
                    state_d  = StCPulse;
                    is_clr_d = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = PULSE_LD;
                end else if (wr_req) begin
                    state_d  = StWSetup;
                    is_clr_d = 1'b0;
                    addr_d   = wr_addr;
                    lat_d_d  = wr_data;
                    tmr_load = 1'b1;
                    tmr_val  = SETUP_LD;
                end
            end
            StWSetup: begin
                if (tmr_zero) begin
                    state_d  = StWOpen;
                    tmr_load = 1'b1;
                    tmr_val  = PULSE_LD;
                end
            end
            StWOpen: begin
                if (tmr_zero) begin
                    state_d  = StWHold;
                    tmr_load = 1'b1;
                    tmr_val  = HOLD_LD;
                end
            end
            StWHold: begin
                if (tmr_zero) state_d = StDone;
            end
            StCPulse: begin
                if (tmr_zero) begin
                    state_d  = StCRec;
                    tmr_load = 1'b1;
                    tmr_val  = HOLD_LD;
                end
            end
            StCRec: begin
                if (tmr_zero) state_d = StDone;
            end
            StDone: begin
                // Only the serviced request's handshake matters here.
                if (is_clr_q ? !clr_req : !wr_req) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Output decode from the next state, so the flops present each phase's
    // controls during exactly the cycles that phase occupies.
    always_comb begin
        gaten_d  = '1;
        resetb_d = '1;
        for (int unsigned i = 0; i < NWORDS; i++) begin
            if (state_d == StWOpen && addr_ok && addr_q == AW'(i)) gaten_d[i] = 1'b0;
        end
        if (state_d == StCPulse) resetb_d = '0;
        wr_ack_d  = (state_d == StDone) && !is_clr_d;
        wr_err_d  = (state_d == StDone) && !is_clr_d && !addr_ok;
        clr_ack_d = (state_d == StDone) && is_clr_d;
        busy_d    = (state_d != StIdle);
    end

    // Reset holds the whole array clear and every gate closed.
    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            is_clr_q   <= 1'b0;
            lat_d      <= '0;
            lat_gaten  <= '1;
            lat_resetb <= '0;
            wr_ack     <= 1'b0;
            wr_err     <= 1'b0;
            clr_ack    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            is_clr_q   <= is_clr_d;
            lat_d      <= lat_d_d;
            lat_gaten  <= gaten_d;
            lat_resetb <= resetb_d;
            wr_ack     <= wr_ack_d;
            wr_err     <= wr_err_d;
            clr_ack    <= clr_ack_d;
            busy       <= busy_d;
        end
    end

endmodule

// File: tb/tb_latch_bank_wr_seq.sv
// tb_latch_bank_wr_seq
// Two sequencers: A with default timing and 8 words, B with 6 words (so
// addresses 6 and 7 are out of range) and timing 3/4/2. Expected outputs come
// from a per-transaction timeline: phase boundaries are computed from the
// cycle counts, not from any model of the state machine.
module tb_latch_bank_wr_seq;

    localparam int unsigned   NW    [2] = '{8, 6};
    localparam int unsigned   SETUP [2] = '{1, 3};
    localparam int unsigned   PULSE [2] = '{2, 4};
    localparam int unsigned   HOLD  [2] = '{1, 2};
    localparam logic [7:0]    ALLW  [2] = '{8'hFF, 8'h3F};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstb;
    logic [1:0] wr_req, clr_req;
    logic [2:0] wr_addr [2];
    logic [7:0] wr_data [2];

    logic [7:0] d_a, g_a, r_a;
    logic [7:0] d_b;
    logic [5:0] g_b, r_b;
    logic       wack_a, err_a, cack_a, busy_a;
    logic       wack_b, err_b, cack_b, busy_b;

    logic [7:0] o_d [2];
    logic [7:0] o_g [2];
    logic [7:0] o_r [2];
    logic       o_wack [2];
    logic       o_err  [2];
    logic       o_cack [2];
    logic       o_busy [2];

    always_comb begin
        o_d[0] = d_a;  o_g[0] = g_a;            o_r[0] = r_a;
        o_d[1] = d_b;  o_g[1] = {2'b11, g_b};   o_r[1] = {2'b11, r_b};
        o_wack[0] = wack_a; o_err[0] = err_a; o_cack[0] = cack_a; o_busy[0] = busy_a;
        o_wack[1] = wack_b; o_err[1] = err_b; o_cack[1] = cack_b; o_busy[1] = busy_b;
    end

    latch_bank_wr_seq #(
        .NWORDS(8), .WIDTH(8), .SETUP_CYC(1), .PULSE_CYC(2), .HOLD_CYC(1)
    ) u_dut_a (
        .CLK(clk), .RESETB(rstb),
        .wr_req(wr_req[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]),
        .wr_ack(wack_a), .wr_err(err_a), .clr_req(clr_req[0]), .clr_ack(cack_a),
        .lat_d(d_a), .lat_gaten(g_a), .lat_resetb(r_a), .busy(busy_a)
    );

    latch_bank_wr_seq #(
        .NWORDS(6), .WIDTH(8), .SETUP_CYC(3), .PULSE_CYC(4), .HOLD_CYC(2)
    ) u_dut_b (
        .CLK(clk), .RESETB(rstb),
        .wr_req(wr_req[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]),
        .wr_ack(wack_b), .wr_err(err_b), .clr_req(clr_req[1]), .clr_ack(cack_b),
        .lat_d(d_b), .lat_gaten(g_b), .lat_resetb(r_b), .busy(busy_b)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [7:0]  model_d [2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outs(input int d, input string tag, input logic [7:0] ed,
                              input logic [7:0] eg, input logic [7:0] er, input logic ewa,
                              input logic ee, input logic eca, input logic eb);
        string t;
        t = $sformatf("%s[%0d]", tag, d);
        check_eq({t, ".lat_d"},      32'(o_d[d]),    32'(ed));
        check_eq({t, ".lat_gaten"},  32'(o_g[d]),    32'(eg));
        check_eq({t, ".lat_resetb"}, 32'(o_r[d]),    32'(er));
        check_eq({t, ".wr_ack"},     32'(o_wack[d]), 32'(ewa));
        check_eq({t, ".wr_err"},     32'(o_err[d]),  32'(ee));
        check_eq({t, ".clr_ack"},    32'(o_cack[d]), 32'(eca));
        check_eq({t, ".busy"},       32'(o_busy[d]), 32'(eb));
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Bank-wide invariants, sampled mid-cycle whenever out of reset.
    always @(negedge clk) begin
        if (rstb === 1'b1) begin
            for (int d = 0; d < 2; d++) begin
                check_eq("inv_one_gate", 32'($countones(~o_g[d]) <= 1), 32'd1);
                check_eq("inv_gate_in_reset",
                         32'((o_r[d] != 8'hFF) && (o_g[d] != 8'hFF)), 32'd0);
            end
        end
    end

    // drop_at = 0 : requester holds wr_req until it sees wr_ack
    // drop_at = k : requester lets go after cycle k of the sequence
    task automatic do_write(input int d, input logic [2:0] addr, input logic [7:0] data,
                            input int drop_at);
        int   n;
        int   hold;
        logic bad;
        logic [7:0] eg;
        n   = int'(SETUP[d] + PULSE[d] + HOLD[d]) + 1;
        bad = (32'(addr) >= NW[d]);
        wr_addr[d] = addr;
        wr_data[d] = data;
        wr_req[d]  = 1'b1;
        model_d[d] = data;
        for (int c = 1; c <= n; c++) begin
            next_cycle();
            // Inputs changing mid-sequence must not disturb anything.
            wr_addr[d] = 3'($urandom);
            wr_data[d] = 8'($urandom);
            eg = 8'hFF;
            if (!bad && c > int'(SETUP[d]) && c <= int'(SETUP[d] + PULSE[d])) eg[addr] = 1'b0;
            check_outs(d, "wr", data, eg, 8'hFF, c == n, bad && (c == n), 1'b0, 1'b1);
            if (c == drop_at) wr_req[d] = 1'b0;
        end
        if (wr_req[d]) begin
            hold = $urandom_range(0, 2);
            for (int h = 0; h < hold; h++) begin
                next_cycle();
                check_outs(d, "wr_hold", data, 8'hFF, 8'hFF, 1'b1, bad, 1'b0, 1'b1);
            end
            wr_req[d] = 1'b0;
        end
        next_cycle();
        check_outs(d, "wr_end", data, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // with_wr raises wr_req on the same edge; the write follows the clear.
    task automatic do_clear(input int d, input logic with_wr, input logic [2:0] addr,
                            input logic [7:0] data);
        int n;
        logic [7:0] er;
        n = int'(PULSE[d] + HOLD[d]) + 1;
        clr_req[d] = 1'b1;
        if (with_wr) begin
            wr_addr[d] = addr;
            wr_data[d] = data;
            wr_req[d]  = 1'b1;
        end
        for (int c = 1; c <= n; c++) begin
            next_cycle();
            er = (c <= int'(PULSE[d])) ? ~ALLW[d] : 8'hFF;
            check_outs(d, "clr", model_d[d], 8'hFF, er, 1'b0, 1'b0, c == n, 1'b1);
        end
        clr_req[d] = 1'b0;
        next_cycle();
        check_outs(d, "clr_end", model_d[d], 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
        if (with_wr) do_write(d, addr, data, 0);
    endtask

    task automatic idle_gap(input int d, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            next_cycle();
            check_outs(d, "idle", model_d[d], 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        int d;
        int op;
        int n;
        int drop;
        logic [2:0] a;

        rstb = 1'b0;
        wr_req = '0;
        clr_req = '0;
        for (int i = 0; i < 2; i++) begin
            wr_addr[i] = '0;
            wr_data[i] = '0;
            model_d[i] = '0;
        end

        // Reset values, then lat_resetb releases on the first edge only.
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++)
            check_outs(i, "reset", 8'h00, 8'hFF, ~ALLW[i], 1'b0, 1'b0, 1'b0, 1'b0);
        rstb = 1'b1;
        #1;
        check_eq("release_pre_edge.lat_resetb", 32'(o_r[0]), 32'h00);
        @(negedge clk);
        for (int i = 0; i < 2; i++)
            check_outs(i, "release", 8'h00, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);

        // Directed cases
        do_write(0, 3'd3, 8'hA5, 0);
        idle_gap(0, 1);
        do_clear(0, 1'b1, 3'd6, 8'h5C);
        do_write(1, 3'd6, 8'h5A, 0);
        do_write(1, 3'd2, 8'hC3, 0);
        do_write(0, 3'd7, 8'h81, 2);
        do_clear(1, 1'b0, 3'd0, 8'h00);

        // Reset during the gate-open phase of A
        wr_addr[0] = 3'd5;
        wr_data[0] = 8'h3C;
        wr_req[0]  = 1'b1;
        for (int c = 0; c <= int'(SETUP[0]); c++) next_cycle();
        check_eq("rst_mid.pre.lat_gaten", 32'(o_g[0]), 32'hDF);
        #1;
        rstb = 1'b0;
        #1;
        model_d[0] = 8'h00;
        model_d[1] = 8'h00;
        check_outs(0, "rst_mid", 8'h00, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        check_outs(1, "rst_mid", 8'h00, 8'hFF, ~ALLW[1], 1'b0, 1'b0, 1'b0, 1'b0);
        wr_req[0] = 1'b0;
        @(negedge clk);
        rstb = 1'b1;
        next_cycle();
        check_outs(0, "rst_mid_rel", 8'h00, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized traffic against the timeline model
        for (int i = 0; i < 80; i++) begin
            d  = $urandom_range(0, 1);
            op = $urandom_range(0, 5);
            a  = 3'($urandom_range(0, 7));
            idle_gap(d, $urandom_range(0, 2));
            if (op <= 3) begin
                n    = int'(SETUP[d] + PULSE[d] + HOLD[d]) + 1;
                drop = ($urandom_range(0, 3) == 0) ? $urandom_range(1, n) : 0;
                do_write(d, a, 8'($urandom), drop);
            end else begin
                do_clear(d, op == 5, a, 8'($urandom));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
